sobel_magnitude_stage: RTL
==========================

SOBEL_MAGNITUDE_STAGE -- requirements
Module: sobel_magnitude_stage

Interface
REQ-001 Parameter NUMPIXELS, default 2097152/2, pixels per frame counted at the output.
REQ-002 Parameter PICW, default 24, width of pixel index and edge counters.
REQ-003 Parameter THRESHOLD, default 64, magnitude at or above which a pixel is an edge.
REQ-004 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port startEn  input  1  stage enable; when low, validIn is ignored.
REQ-007 Port validIn  input  1  sobelX/sobelY hold a valid gradient pair this cycle.
REQ-008 Port sobelX  input  9  signed horizontal gradient from the Sobel multiplier stage.
REQ-009 Port sobelY  input  9  signed vertical gradient from the Sobel multiplier stage.
REQ-010 Port validOut  output  1  output fields valid this cycle.
REQ-011 Port magnitude  output  8  saturated |X|+|Y|.
REQ-012 Port direction  output  2  quantised gradient angle: 0=0deg, 1=45deg, 2=90deg, 3=135deg.
REQ-013 Port edgeFlag  output  1  magnitude >= THRESHOLD.
REQ-014 Port pixelIndex  output  PICW  index within the frame of the current output pixel.
REQ-015 Port frameDone  output  1  one-cycle pulse coincident with the last pixel of a frame.
REQ-016 Port edgeCount  output  PICW  edge total of the last completed frame.

Function
REQ-017 Accepted sample = validIn AND startEn; each accepted sample yields exactly one validOut pulse, exactly 3 cycles later, in order; throughput is 1 per cycle.
REQ-018 Stage 1 registers |sobelX| and |sobelY| as 9-bit unsigned (|-256| = 256), and the flag signsAgree = (sign X == sign Y).
REQ-019 Stage 2 registers sum = |X|+|Y| (10 bits, max 512) and the comparisons A = |Y|*256 < |X|*106 and B = |Y|*256 > |X|*618, computed in 18-bit unsigned arithmetic without overflow.
REQ-020 Direction is 0 if A, else 2 if B, else 1 if signsAgree, else 3; it is 0 when both inputs are zero.
REQ-021 Stage 3 sets magnitude = 255 when sum > 255, else sum[7:0]; edgeFlag = (saturated magnitude >= THRESHOLD).
REQ-022 The pixel counter advances by 1 on each validOut and wraps from NUMPIXELS-1 to 0; pixelIndex shows the pre-increment value.
REQ-023 frameDone = 1 for exactly the validOut cycle with pixelIndex = NUMPIXELS-1.
REQ-024 The running edge counter increments on each validOut with edgeFlag = 1; on frameDone, edgeCount is loaded with the final total, including the last pixel, and the running counter clears to 0.
REQ-025 Bubbles (no accepted sample) propagate as validOut = 0; in a bubble cycle magnitude, direction and edgeFlag hold their previous values and the counters hold.
REQ-026 Deasserting startEn does not flush the pipeline; samples already accepted still emerge.

Reset
REQ-027 Reset asserted clears, without waiting for clk, all pipeline valids, data registers, pixel counter, running edge counter, edgeCount, validOut, magnitude, direction, edgeFlag, pixelIndex and frameDone to 0.
REQ-028 Reset asserted mid-frame discards in-flight samples; the first accepted sample after reset release is pixelIndex 0.

Structure
REQ-029 The shared sobel package holds the direction codes (DIR_0, DIR_45, DIR_90, DIR_135), the tangent constants 106 and 618, and the gradient width 9.
REQ-030 One sub-module, sobel_dir_quant, implements the combinational stage-2 comparison and direction select; everything else stays in the top module.

Verification
REQ-031 Test 1: X=100, Y=0 accepted at cycle t (THRESHOLD=64). Required: at t+3, validOut=1, magnitude=100, direction=0, edgeFlag=1.
REQ-032 Test 2: X=-256, Y=-256. Required: magnitude=255 (saturated), direction=1. Then X=50, Y=-50. Required: magnitude=100, direction=3.
REQ-033 Test 3: X=0, Y=30. Required: magnitude=30, direction=2, edgeFlag=0. Then X=0, Y=0. Required: magnitude=0, direction=0.
REQ-034 Test 4: NUMPIXELS=4, eight back-to-back samples with 3 edges per frame. Required: pixelIndex sequence 0,1,2,3,0,1,2,3; frameDone on the 4th and 8th outputs; edgeCount=3 after each frameDone.
REQ-035 Test 5: validIn=1 with startEn=0 for 5 cycles. Required: no validOut and counters unchanged. Then reset pulsed between clock edges mid-stream. Required: all outputs 0 immediately and the next output has pixelIndex=0.

Source files
------------

// File: rtl/sobel_magnitude_stage_pkg.sv
// Shared definitions for the Sobel magnitude/direction stage.
//   GRAD_W  : width of the signed gradient inputs
//   TAN_LO  : tan(22.5 deg) * 256, lower sector boundary
//   TAN_HI  : tan(67.5 deg) * 256, upper sector boundary
//   CMP_W   : width of the sector comparison arithmetic
//   dir_t   : quantised gradient direction codes
//   abs_grad: absolute value of a signed gradient, -256 maps to 256
package sobel_magnitude_stage_pkg;

  localparam int GRAD_W = 9;
  localparam int TAN_LO = 106;
  localparam int TAN_HI = 618;
  localparam int CMP_W  = 18;

  typedef enum logic [1:0] {
    DIR_0   = 2'd0,
    DIR_45  = 2'd1,
    DIR_90  = 2'd2,
    DIR_135 = 2'd3
  } dir_t;

  // Result is unsigned, so the most negative input still has a valid magnitude.
  function automatic logic [GRAD_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
    logic [GRAD_W-1:0] u;
    u = g;
    return g[GRAD_W-1] ? ((~u) + GRAD_W'(1)) : u;
  endfunction

endpackage

// File: rtl/sobel_dir_quant.sv
// Combinational direction quantiser.
//   abs_x, abs_y : unsigned gradient magnitudes
//   signs_agree  : gradient components have the same sign
//   direction    : quantised angle (0, 45, 90, 135 degrees)
module sobel_dir_quant
  import sobel_magnitude_stage_pkg::*;
(
  input  logic [GRAD_W-1:0] abs_x,
  input  logic [GRAD_W-1:0] abs_y,
  input  logic              signs_agree,
  output dir_t              direction
);

  logic [CMP_W-1:0] y_scaled;
  logic [CMP_W-1:0] x_lo;
  logic [CMP_W-1:0] x_hi;
  logic             below_lo;
  logic             above_hi;
  logic             both_zero;

  // |Y|/|X| against tan(22.5) and tan(67.5) without division; 18 bits holds 256*618.
  assign y_scaled  = CMP_W'(abs_y) << 8;
  assign x_lo      = CMP_W'(abs_x) * CMP_W'(TAN_LO);
  assign x_hi      = CMP_W'(abs_x) * CMP_W'(TAN_HI);
  assign below_lo  = y_scaled < x_lo;
  assign above_hi  = y_scaled > x_hi;
  assign both_zero = (abs_x == '0) && (abs_y == '0);

  always_comb begin
    direction = DIR_45;
    if (both_zero) begin
      direction = DIR_0;
    end else if (below_lo) begin
      direction = DIR_0;
    end else if (above_hi) begin
      direction = DIR_90;
    end else if (signs_agree) begin
      direction = DIR_45;
    end else begin
      direction = DIR_135;
    end
  end

endmodule

// File: rtl/sobel_magnitude_stage.sv
// Three-stage Sobel magnitude/direction stage with per-frame edge counting.
//   clk, reset          : clock, asynchronous active-high reset
//   startEn, validIn    : a sample is accepted when both are high
//   sobelX, sobelY      : signed gradients
//   validOut            : output fields valid (3 cycles after acceptance)
//   magnitude           : saturated |X|+|Y|
//   direction           : quantised gradient angle
//   edgeFlag            : magnitude >= THRESHOLD
//   pixelIndex          : index of the current output pixel within the frame
//   frameDone           : pulse with the last pixel of a frame
//   edgeCount           : edge total of the last completed frame
module sobel_magnitude_stage
  import sobel_magnitude_stage_pkg::*;
#(
  parameter int NUMPIXELS = 2097152/2,
  parameter int PICW      = 24,
  parameter int THRESHOLD = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     startEn,
  input  logic                     validIn,
  input  logic signed [GRAD_W-1:0] sobelX,
  input  logic signed [GRAD_W-1:0] sobelY,
  output logic                     validOut,
  output logic [7:0]               magnitude,
  output logic [1:0]               direction,
  output logic                     edgeFlag,
  output logic [PICW-1:0]          pixelIndex,
  output logic                     frameDone,
  output logic [PICW-1:0]          edgeCount
);

  localparam logic [PICW-1:0] LAST_PIX = PICW'(NUMPIXELS - 1);
  localparam logic [8:0]      THR      = 9'(THRESHOLD);

  logic              accept;

  logic              s1_valid;
  logic [GRAD_W-1:0] s1_abs_x;
  logic [GRAD_W-1:0] s1_abs_y;
  logic              s1_agree;

  logic              s2_valid;
  logic [GRAD_W:0]   s2_sum;
  dir_t              s2_dir;
  dir_t              q_dir;

  logic [7:0]        mag_sat;
  logic              edge_new;
  logic              last_pix;

  logic [PICW-1:0]   pix_cnt;
  logic [PICW-1:0]   edge_run;

  assign accept = validIn & startEn;

  sobel_dir_quant u_dir_quant (
    .abs_x       (s1_abs_x),
    .abs_y       (s1_abs_y),
    .signs_agree (s1_agree),
    .direction   (q_dir)
  );

  assign mag_sat  = (s2_sum > (GRAD_W+1)'(255)) ? 8'hFF : s2_sum[7:0];
  assign edge_new = {1'b0, mag_sat} >= THR;
  assign last_pix = pix_cnt == LAST_PIX;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_abs_x   <= '0;
      s1_abs_y   <= '0;
      s1_agree   <= 1'b0;
      s2_valid   <= 1'b0;
      s2_sum     <= '0;
      s2_dir     <= DIR_0;
      validOut   <= 1'b0;
      magnitude  <= '0;
      direction  <= '0;
      edgeFlag   <= 1'b0;
      pixelIndex <= '0;
      frameDone  <= 1'b0;
      edgeCount  <= '0;
      pix_cnt    <= '0;
      edge_run   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_abs_x <= abs_grad(sobelX);
        s1_abs_y <= abs_grad(sobelY);
        s1_agree <= sobelX[GRAD_W-1] == sobelY[GRAD_W-1];
      end

      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sum <= {1'b0, s1_abs_x} + {1'b0, s1_abs_y};
        s2_dir <= q_dir;
      end

      validOut  <= s2_valid;
      frameDone <= s2_valid & last_pix;
      if (s2_valid) begin
        magnitude  <= mag_sat;
        direction  <= s2_dir;
        edgeFlag   <= edge_new;
        pixelIndex <= pix_cnt;
        if (last_pix) begin
          pix_cnt   <= '0;
          // The last pixel's own edge is folded into the reported total.
          edgeCount <= edge_run + PICW'(edge_new);
          edge_run  <= '0;
        end else begin
          pix_cnt  <= pix_cnt + PICW'(1);
          edge_run <= edge_run + PICW'(edge_new);
        end
      end
    end
  end

endmodule
